// File: rtl/scanline_pos_ctrl.sv
// Scanline position sequencer: a vertical phase accumulator that produces per-line scanline controls.
// Building with SCANLINE_POS_INTERLACE_EN adds a half-line phase shift on odd fields.
module scanline_pos_ctrl #(
    parameter int LINE_CNT_W = 11
) (
    input  logic                  VCLK_i,
    input  logic                  VRST_i,
    input  logic                  HSYNC_i,
    input  logic                  VSYNC_i,
    input  logic                  DE_i,
    input  logic                  sl_en_i,
    input  logic                  sl_thickness_i,
    input  logic [7:0]            sl_strength_i,
    input  logic [15:0]           sl_phase_inc_i,
    input  logic [7:0]            sl_phase_ofs_i,
    output logic                  sl_en_o,
    output logic                  sl_thickness_o,
    output logic [7:0]            sl_strength_o,
    output logic [7:0]            sl_rel_pos_o,
    output logic [LINE_CNT_W-1:0] src_line_o,
    output logic                  new_src_line_o
);

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        VBLANK     = 2'd1,
        ACTIVE     = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic                    vsync_q, de_q;
    logic                    en_sh_q, en_sh_d;
    logic                    thick_q, thick_d;
    logic [7:0]              str_q, str_d;
    logic [15:0]             inc_q, inc_d;
    logic [15:0]             phase_q, phase_d;
    logic [LINE_CNT_W-1:0]   src_q, src_d;
    logic                    pulse_q, pulse_d;
    logic [7:0]              rel_q, rel_d;
    logic                    sl_en_q, sl_en_d;
    logic                    vs_fall_s, de_rise_s, de_fall_s, line_end_s;
    logic [16:0]             sum_s;
    logic [15:0]             phase_init_s;
`ifdef SCANLINE_POS_INTERLACE_EN
    logic                    field_q, field_d;
`endif

    // Line centre is half an increment past the line's starting phase; inc == 0 parks it mid-line.
    function automatic logic [7:0] rel_pos(input logic [15:0] ph, input logic [15:0] inc);
        if (inc == 16'h0000) begin
            rel_pos = 8'h80;
        end else begin
            rel_pos = 8'((ph + {1'b0, inc[15:1]}) >> 4'd8);
        end
    endfunction

    assign vs_fall_s  = vsync_q & ~VSYNC_i;
    assign de_rise_s  = DE_i & ~de_q & HSYNC_i;
    assign de_fall_s  = de_q & ~DE_i;
    assign line_end_s = de_fall_s & (state_q == ACTIVE) & ~vs_fall_s;
    assign sum_s      = {1'b0, phase_q} + {1'b0, inc_q};

`ifdef SCANLINE_POS_INTERLACE_EN
    assign phase_init_s = {sl_phase_ofs_i, 8'h00}
                        + (field_q ? {1'b0, sl_phase_inc_i[15:1]} : 16'h0000);
`else
    assign phase_init_s = {sl_phase_ofs_i, 8'h00};
`endif

    // Next-state: frame/line sequencing, config shadowing and phase accumulation.
    always_comb begin
        state_d = state_q;
        en_sh_d = en_sh_q;
        thick_d = thick_q;
        str_d   = str_q;
        inc_d   = inc_q;
        phase_d = phase_q;
        src_d   = src_q;
        pulse_d = 1'b0;
        rel_d   = rel_q;
        sl_en_d = sl_en_q;
`ifdef SCANLINE_POS_INTERLACE_EN
        field_d = field_q;
`endif
        case (state_q)
            WAIT_FRAME: if (vs_fall_s) state_d = VBLANK; else state_d = WAIT_FRAME;
            VBLANK:     if (vs_fall_s) state_d = VBLANK; else if (de_rise_s) state_d = ACTIVE; else state_d = VBLANK;
            ACTIVE:     if (vs_fall_s) state_d = VBLANK; else state_d = ACTIVE;
            default:    state_d = WAIT_FRAME;
        endcase

        // Frame start wins over a line end landing on the same cycle.
        if (vs_fall_s) begin
            en_sh_d = sl_en_i;
            thick_d = sl_thickness_i;
            str_d   = sl_strength_i;
            inc_d   = sl_phase_inc_i;
            phase_d = phase_init_s;
            src_d   = {LINE_CNT_W{1'b0}};
`ifdef SCANLINE_POS_INTERLACE_EN
            field_d = ~field_q;
`endif
        end else if (line_end_s) begin
            phase_d = sum_s[15:0];
            if (sum_s[16]) begin
                pulse_d = 1'b1;
                if (src_q != {LINE_CNT_W{1'b1}}) begin
                    src_d = src_q + {{(LINE_CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    src_d = src_q;
                end
            end else begin
                pulse_d = 1'b0;
            end
        end else begin
            phase_d = phase_q;
        end

        if (vs_fall_s || line_end_s) begin
            rel_d   = rel_pos(phase_d, inc_d);
            sl_en_d = en_sh_d & (inc_d != 16'h0000) & (state_d != WAIT_FRAME);
        end else begin
            rel_d   = rel_q;
        end
    end

    // State, edge-detect history, shadows and registered outputs.
    always_ff @(posedge VCLK_i or posedge VRST_i) begin
        if (VRST_i) begin
            state_q <= WAIT_FRAME;
            vsync_q <= 1'b1;
            de_q    <= 1'b0;
            en_sh_q <= 1'b0;
            thick_q <= 1'b0;
            str_q   <= 8'h00;
            inc_q   <= 16'h0000;
            phase_q <= 16'h0000;
            src_q   <= {LINE_CNT_W{1'b0}};
            pulse_q <= 1'b0;
            rel_q   <= 8'h80;
            sl_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            vsync_q <= VSYNC_i;
            de_q    <= DE_i;
            en_sh_q <= en_sh_d;
            thick_q <= thick_d;
            str_q   <= str_d;
            inc_q   <= inc_d;
            phase_q <= phase_d;
            src_q   <= src_d;
            pulse_q <= pulse_d;
            rel_q   <= rel_d;
            sl_en_q <= sl_en_d;
        end
    end

`ifdef SCANLINE_POS_INTERLACE_EN
    // Field parity register.
    always_ff @(posedge VCLK_i or posedge VRST_i) begin
        if (VRST_i) begin
            field_q <= 1'b0;
        end else begin
            field_q <= field_d;
        end
    end
`endif

    assign sl_en_o        = sl_en_q;
    assign sl_thickness_o = thick_q;
    assign sl_strength_o  = str_q;
    assign sl_rel_pos_o   = rel_q;
    assign src_line_o     = src_q;
    assign new_src_line_o = pulse_q;

endmodule

// File: tb/tb_scanline_pos_ctrl.sv
// Bench for scanline_pos_ctrl: directed frames/lines checked against an arithmetic phase model.
module tb_scanline_pos_ctrl;
    localparam int LW      = 11;
    localparam int SRC_MAX = (1 << LW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, hs, vs, de, en_i, thk_i;
    logic [7:0]    str_i, ofs_i;
    logic [15:0]   inc_i;
    logic          sl_en_o, thk_o, nsl_o;
    logic [7:0]    str_o, rel_o;
    logic [LW-1:0] src_o;

    scanline_pos_ctrl #(.LINE_CNT_W(LW)) dut (
        .VCLK_i(clk), .VRST_i(rst), .HSYNC_i(hs), .VSYNC_i(vs), .DE_i(de),
        .sl_en_i(en_i), .sl_thickness_i(thk_i), .sl_strength_i(str_i),
        .sl_phase_inc_i(inc_i), .sl_phase_ofs_i(ofs_i),
        .sl_en_o(sl_en_o), .sl_thickness_o(thk_o), .sl_strength_o(str_o),
        .sl_rel_pos_o(rel_o), .src_line_o(src_o), .new_src_line_o(nsl_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: 0 = waiting for frame, 1 = vertical blank, 2 = active
    int   m_state, m_phase, m_inc, m_src, m_str;
    logic m_en, m_thk;
`ifdef SCANLINE_POS_INTERLACE_EN
    int   m_field;
`endif
    int   e_rel, e_src, e_str, e_pulse;
    logic e_en, e_thk;

    logic        line_chk = 1'b0;
    int          req_seq  = 0;
    logic [31:0] last_rel, last_src, last_str;
    logic [31:0] lrel [8];
    logic [31:0] lsrc [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_phase = 0; m_inc = 0; m_src = 0; m_str = 0;
        m_en = 1'b0; m_thk = 1'b0; e_pulse = 0;
`ifdef SCANLINE_POS_INTERLACE_EN
        m_field = 0;
`endif
    endtask

    task automatic frame_model();
        m_en = en_i; m_thk = thk_i; m_str = int'(str_i); m_inc = int'(inc_i);
        m_phase = int'(ofs_i) * 256;
`ifdef SCANLINE_POS_INTERLACE_EN
        if (m_field == 1) m_phase = (m_phase + m_inc / 2) % 65536;
        m_field = 1 - m_field;
`endif
        m_src = 0; m_state = 1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_sl_en"}, sl_en_o, 32'd0);
        chk({tag, "_thick"}, thk_o, 32'd0);
        chk({tag, "_strength"}, str_o, 32'd0);
        chk({tag, "_rel_pos"}, rel_o, 32'h80);
        chk({tag, "_src_line"}, src_o, 32'd0);
        chk({tag, "_new_src"}, nsl_o, 32'd0);
    endtask

    task automatic set_cfg(input logic en, input logic thk, input logic [7:0] str,
                           input logic [15:0] inc, input logic [7:0] ofs);
        en_i = en; thk_i = thk; str_i = str; inc_i = inc; ofs_i = ofs;
    endtask

    task automatic do_frame_start();
        vs = 1'b0;
        frame_model();
        repeat (2) @(posedge clk);
        #1 vs = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_line(input int hi, input int lo, input logic hs_a, input logic vs_end);
        int s;
        if (m_state == 1 && hs_a) m_state = 2;
        e_en  = (m_state != 0) && m_en && (m_inc != 0);
        e_rel = (m_inc == 0) ? 128 : ((m_phase + m_inc / 2) / 256) % 256;
        e_src = m_src; e_str = m_str; e_thk = m_thk;
        hs = hs_a; de = 1'b1; line_chk = 1'b1; req_seq++;
        @(negedge clk);
        last_rel = 32'(rel_o); last_src = 32'(src_o); last_str = 32'(str_o);
        repeat (hi) @(posedge clk);
        #1;
        line_chk = 1'b0; de = 1'b0;
        if (vs_end) begin
            vs = 1'b0;
            frame_model();
            e_pulse = 0;
        end else if (m_state == 2) begin
            s = m_phase + m_inc;
            m_phase = s % 65536;
            if (s >= 65536) begin
                e_pulse = 1;
                if (m_src < SRC_MAX) m_src++;
            end else begin
                e_pulse = 0;
            end
        end else begin
            e_pulse = 0;
        end
        repeat (lo) @(posedge clk);
        #1;
        hs = 1'b1; vs = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        #1;
        check_reset_outputs("frame_gap_reset");
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic reset_mid_line();
        hs = 1'b1; de = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check_reset_outputs("mid_line_reset");
        model_reset();
        @(posedge clk);
        #1 de = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Compare process: outputs checked every active-line cycle, pulses counted across blanking.
    initial begin
        int pulse_cnt;
        int ack_seq;
        pulse_cnt = 0;
        ack_seq   = 0;
        forever begin
            @(negedge clk);
            if (rst) pulse_cnt = 0;
            else if (nsl_o !== 1'b0) pulse_cnt++;
            if (de && line_chk) begin
                if (req_seq != ack_seq) begin
                    chk("new_src_pulse_count", pulse_cnt, e_pulse);
                    pulse_cnt = 0;
                    ack_seq   = req_seq;
                end
                chk("sl_rel_pos", rel_o, e_rel);
                chk("sl_en", sl_en_o, {31'd0, e_en});
                chk("src_line", src_o, e_src);
                chk("sl_strength", str_o, e_str);
                chk("sl_thickness", thk_o, {31'd0, e_thk});
            end
        end
    end

    initial begin
        rst = 1'b1; hs = 1'b1; vs = 1'b1; de = 1'b0;
        set_cfg(1'b0, 1'b0, 8'h00, 16'h0000, 8'h00);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("por");
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        do_line(3, 3, 1'b1, 1'b0);

        // inc = 1/2: two output lines per source line
        set_cfg(1'b1, 1'b1, 8'h40, 16'h8000, 8'h00);
        do_frame_start();
        for (int i = 0; i < 4; i++) begin
            do_line(3, 3, 1'b1, 1'b0);
            lrel[i] = last_rel; lsrc[i] = last_src;
            if (i == 1) str_i = 8'hC0;
        end
        chk("half_rel0", lrel[0], 32'h40); chk("half_rel1", lrel[1], 32'hC0);
        chk("half_rel2", lrel[2], 32'h40); chk("half_rel3", lrel[3], 32'hC0);
        chk("half_src1", lsrc[1], 32'd0);  chk("half_src2", lsrc[2], 32'd1);
        chk("half_src3", lsrc[3], 32'd1);
        chk("strength_held_midframe", last_str, 32'h40);

        do_frame_start();
        do_line(3, 3, 1'b1, 1'b0);
`ifdef SCANLINE_POS_INTERLACE_EN
        chk("odd_field_first_rel", last_rel, 32'h80);
`else
        chk("second_frame_first_rel", last_rel, 32'h40);
`endif
        chk("strength_after_vsync", last_str, 32'hC0);
        do_line(3, 3, 1'b1, 1'b0);

        // inc = 1/3
        reset_pulse();
        set_cfg(1'b1, 1'b0, 8'h20, 16'h5555, 8'h00);
        do_frame_start();
        for (int i = 0; i < 5; i++) begin
            do_line(3, 3, 1'b1, 1'b0);
            lrel[i] = last_rel; lsrc[i] = last_src;
        end
        chk("third_rel0", lrel[0], 32'h2A); chk("third_rel1", lrel[1], 32'h7F);
        chk("third_rel2", lrel[2], 32'hD5); chk("third_rel3", lrel[3], 32'h2A);
        chk("third_src3", lsrc[3], 32'd0);  chk("third_src4", lsrc[4], 32'd1);

        // inc = 0: scanlines off, position parked
        set_cfg(1'b1, 1'b1, 8'h77, 16'h0000, 8'h10);
        do_frame_start();
        for (int i = 0; i < 3; i++) do_line(3, 3, 1'b1, 1'b0);
        chk("inc0_rel", last_rel, 32'h80);

        // DE while HSYNC low ignored; last line ends together with VSYNC
        set_cfg(1'b1, 1'b0, 8'h33, 16'h3000, 8'h20);
        do_frame_start();
        do_line(3, 3, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) do_line(3, 3, 1'b1, 1'b0);
        set_cfg(1'b1, 1'b0, 8'h11, 16'hFFFF, 8'h00);
        do_line(3, 3, 1'b1, 1'b1);

        // Long frame: source-line counter saturates
        for (int i = 0; i < 2100; i++) do_line(1, 1, 1'b1, 1'b0);
        chk("src_line_saturated", last_src, SRC_MAX);

        reset_mid_line();
        do_line(3, 3, 1'b1, 1'b0);
        do_line(3, 3, 1'b1, 1'b0);
        set_cfg(1'b1, 1'b1, 8'h5A, 16'h4000, 8'h80);
        do_frame_start();
        for (int i = 0; i < 3; i++) begin
            do_line(3, 3, 1'b1, 1'b0);
            lrel[i] = last_rel;
        end
        chk("ofs_rel0", lrel[0], 32'hA0);
        chk("ofs_rel2", lrel[2], 32'h20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
